// File: rtl/fetch_prefetch_unit.sv
// fetch_prefetch_unit: instruction fetch stage with PC, synchronous
// instruction memory (instBank) and a first-word-fall-through prefetch FIFO.
// Downstream handshake is valid/ready; redirect flushes and reloads the PC.
// Optional halt detection is enabled by defining FETCH_HALT_DETECT_EN.
module fetch_prefetch_unit #(
    parameter int unsigned       DATA_W     = 32,
    parameter int unsigned       MEM_DEPTH  = 64,
    parameter int unsigned       FIFO_DEPTH = 4,
    parameter logic [DATA_W-1:0] RESET_PC   = 32'h0000_0000,
    parameter logic [DATA_W-1:0] HALT_WORD  = 32'hFFFF_FFFF
) (
    input  logic                            clk_CPU,
    input  logic                            rst_CPU_n,
    input  logic                            en_fetch,
    input  logic                            redirect,
    input  logic [DATA_W-1:0]               redirect_pc,
    input  logic                            inst_ready,
    output logic                            inst_valid,
    output logic [DATA_W-1:0]               instruccion,
    output logic [DATA_W-1:0]               inst_pc,
    output logic [$clog2(FIFO_DEPTH):0]     fifo_count,
    output logic [DATA_W-1:0]               pc_out,
    output logic                            halted
);

    localparam int unsigned AW = $clog2(MEM_DEPTH);
    localparam int unsigned PW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam logic [CW:0] FIFO_LIMIT = (CW+1)'(FIFO_DEPTH);

    // Instruction memory, preloaded externally (no write port).
    logic [DATA_W-1:0] instBank [MEM_DEPTH];

    logic [DATA_W-1:0] pc_q, pc_d;
    logic              inflight_q, inflight_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic [DATA_W-1:0] pcq_q, pcq_d;
    logic [PW-1:0]     head_q, head_d;
    logic [PW-1:0]     tail_q, tail_d;
    logic [CW-1:0]     count_q, count_d;
    logic              halted_q, halted_d;
    logic [DATA_W-1:0] fifo_data_q [FIFO_DEPTH];
    logic [DATA_W-1:0] fifo_data_d [FIFO_DEPTH];
    logic [DATA_W-1:0] fifo_pc_q   [FIFO_DEPTH];
    logic [DATA_W-1:0] fifo_pc_d   [FIFO_DEPTH];

    logic        halt_pending;
    logic        issue;
    logic        push;
    logic        pop;
    logic [CW:0] credit_used;
    logic        unused_bits;

`ifdef FETCH_HALT_DETECT_EN
    assign halt_pending = inflight_q & (rdata_q == HALT_WORD);
`else
    assign halt_pending = 1'b0;
`endif

    assign unused_bits = ^{redirect_pc[1:0], HALT_WORD};

    // Credit counts the inflight read, so a push can never hit a full FIFO.
    assign credit_used = (CW+1)'(count_q) + (CW+1)'(inflight_q);
    assign issue = en_fetch & ~redirect & ~halted_q & ~halt_pending
                 & (credit_used < FIFO_LIMIT);
    assign push  = inflight_q & ~redirect;
    assign pop   = (count_q != '0) & inst_ready & ~redirect;

    assign inst_valid  = (count_q != '0);
    assign instruccion = inst_valid ? fifo_data_q[head_q] : '0;
    assign inst_pc     = inst_valid ? fifo_pc_q[head_q]   : '0;
    assign fifo_count  = count_q;
    assign pc_out      = pc_q;
    assign halted      = halted_q;

    // Next-state: redirect overrides issue, push and pop.
    always_comb begin
        pc_d        = pc_q;
        inflight_d  = 1'b0;
        rdata_d     = rdata_q;
        pcq_d       = pcq_q;
        head_d      = head_q;
        tail_d      = tail_q;
        count_d     = count_q;
        halted_d    = halted_q;
        fifo_data_d = fifo_data_q;
        fifo_pc_d   = fifo_pc_q;

        if (redirect) begin
            pc_d     = {redirect_pc[DATA_W-1:2], 2'b00};
            head_d   = '0;
            tail_d   = '0;
            count_d  = '0;
            halted_d = 1'b0;
        end else begin
            if (issue) begin
                rdata_d    = instBank[pc_q[AW+1:2]];
                pcq_d      = pc_q;
                pc_d       = pc_q + DATA_W'(4);
                inflight_d = 1'b1;
            end
            if (push) begin
                fifo_data_d[tail_q] = rdata_q;
                fifo_pc_d[tail_q]   = pcq_q;
                tail_d              = tail_q + PW'(1);
                if (halt_pending) begin
                    halted_d = 1'b1;
                end
            end
            if (pop) begin
                head_d = head_q + PW'(1);
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk_CPU or negedge rst_CPU_n) begin
        if (!rst_CPU_n) begin
            pc_q        <= RESET_PC;
            inflight_q  <= 1'b0;
            rdata_q     <= '0;
            pcq_q       <= '0;
            head_q      <= '0;
            tail_q      <= '0;
            count_q     <= '0;
            halted_q    <= 1'b0;
            fifo_data_q <= '{default: '0};
            fifo_pc_q   <= '{default: '0};
        end else begin
            pc_q        <= pc_d;
            inflight_q  <= inflight_d;
            rdata_q     <= rdata_d;
            pcq_q       <= pcq_d;
            head_q      <= head_d;
            tail_q      <= tail_d;
            count_q     <= count_d;
            halted_q    <= halted_d;
            fifo_data_q <= fifo_data_d;
            fifo_pc_q   <= fifo_pc_d;
        end
    end

endmodule

// File: tb/tb_fetch_prefetch_unit.sv
// Testbench for fetch_prefetch_unit: scoreboard of expected {word, pc}
// pairs, popped and compared on each downstream handshake.
module tb_fetch_prefetch_unit;

    logic        clk_CPU = 1'b0;
    logic        rst_CPU_n;
    logic        en_fetch;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        inst_ready;
    logic        inst_valid;
    logic [31:0] instruccion;
    logic [31:0] inst_pc;
    logic [2:0]  fifo_count;
    logic [31:0] pc_out;
    logic        halted;

    typedef struct packed {
        logic [31:0] data;
        logic [31:0] pc;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        e;
    logic [31:0] model_bank [64];
    int          errors = 0;
    int          checks = 0;

    fetch_prefetch_unit #(
        .DATA_W(32), .MEM_DEPTH(64), .FIFO_DEPTH(4),
        .RESET_PC(32'h0000_0000), .HALT_WORD(32'hFFFF_FFFF)
    ) dut (
        .clk_CPU(clk_CPU), .rst_CPU_n(rst_CPU_n), .en_fetch(en_fetch),
        .redirect(redirect), .redirect_pc(redirect_pc), .inst_ready(inst_ready),
        .inst_valid(inst_valid), .instruccion(instruccion), .inst_pc(inst_pc),
        .fifo_count(fifo_count), .pc_out(pc_out), .halted(halted)
    );

    always #5 clk_CPU = ~clk_CPU;

    task automatic tick();
        @(posedge clk_CPU);
        #1;
    endtask

    task automatic enqueue(input logic [31:0] start, input int n);
        logic [31:0] p;
        for (int k = 0; k < n; k++) begin
            p = start + 32'(4 * k);
            exp_q.push_back('{data: model_bank[p[7:2]], pc: p});
        end
    endtask

    task automatic do_reset();
        rst_CPU_n = 1'b0; en_fetch = 1'b0; inst_ready = 1'b0;
        redirect = 1'b0; redirect_pc = '0;
        exp_q.delete();
        repeat (2) @(posedge clk_CPU);
        #1;
        rst_CPU_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_CPU_n = 1'b0; en_fetch = 1'b1; inst_ready = 1'b1;
        redirect = 1'b0; redirect_pc = '0;
        #1;
        checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", inst_valid); end
        checks++; if (instruccion !== 32'h0) begin errors++; $display("FAIL reset_instr: got %h expected 0", instruccion); end
        checks++; if (inst_pc !== 32'h0) begin errors++; $display("FAIL reset_inst_pc: got %h expected 0", inst_pc); end
        checks++; if (fifo_count !== 3'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", fifo_count); end
        checks++; if (pc_out !== 32'h0) begin errors++; $display("FAIL reset_pc_out: got %h expected 0", pc_out); end
        checks++; if (halted !== 1'b0) begin errors++; $display("FAIL reset_halted: got %b expected 0", halted); end
    endtask

    task automatic test_stream();
        do_reset();
        en_fetch = 1'b1; inst_ready = 1'b1;
        enqueue(32'h0, 12);
        tick();
        checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL latency_e0: valid got %b expected 0", inst_valid); end
        tick();
        checks++; if (inst_valid !== 1'b1) begin errors++; $display("FAIL latency_e1: valid got %b expected 1", inst_valid); end
        checks++; if (pc_out !== 32'h8) begin errors++; $display("FAIL latency_pc: got %h expected 8", pc_out); end
        for (int cyc = 0; cyc < 12; cyc++) begin
            checks++; if (inst_valid !== 1'b1) begin errors++; $display("FAIL stream_throughput: cycle %0d valid got %b expected 1", cyc, inst_valid); end
            if (inst_valid && exp_q.size() != 0) begin
                e = exp_q.pop_front();
                checks++; if (instruccion !== e.data) begin errors++; $display("FAIL stream_word: got %h expected %h", instruccion, e.data); end
                checks++; if (inst_pc !== e.pc) begin errors++; $display("FAIL stream_pc: got %h expected %h", inst_pc, e.pc); end
            end
            tick();
        end
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL stream_timeout: %0d words left expected 0", exp_q.size()); end
    endtask

    task automatic test_backpressure();
        do_reset();
        en_fetch = 1'b1; inst_ready = 1'b0;
        repeat (10) tick();
        checks++; if (fifo_count !== 3'd4) begin errors++; $display("FAIL bp_count: got %0d expected 4", fifo_count); end
        checks++; if (pc_out !== 32'h10) begin errors++; $display("FAIL bp_pc_out: got %h expected 10", pc_out); end
        checks++; if (instruccion !== 32'h1) begin errors++; $display("FAIL bp_head: got %h expected 1", instruccion); end
        inst_ready = 1'b1;
        enqueue(32'h0, 8);
        for (int cyc = 0; cyc < 40 && exp_q.size() != 0; cyc++) begin
            if (inst_valid && inst_ready) begin
                e = exp_q.pop_front();
                checks++; if (instruccion !== e.data) begin errors++; $display("FAIL bp_word: got %h expected %h", instruccion, e.data); end
                checks++; if (inst_pc !== e.pc) begin errors++; $display("FAIL bp_pc: got %h expected %h", inst_pc, e.pc); end
            end
            tick();
        end
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL bp_timeout: %0d words left expected 0", exp_q.size()); end
    endtask

    task automatic test_redirect();
        do_reset();
        en_fetch = 1'b1; inst_ready = 1'b0;
        repeat (3) tick();
        checks++; if (fifo_count !== 3'd2) begin errors++; $display("FAIL redir_pre_count: got %0d expected 2", fifo_count); end
        redirect = 1'b1; redirect_pc = 32'h23;
        tick();
        redirect = 1'b0;
        checks++; if (fifo_count !== 3'd0) begin errors++; $display("FAIL redir_count: got %0d expected 0", fifo_count); end
        checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL redir_valid: got %b expected 0", inst_valid); end
        checks++; if (instruccion !== 32'h0) begin errors++; $display("FAIL redir_instr_zero: got %h expected 0", instruccion); end
        checks++; if (pc_out !== 32'h20) begin errors++; $display("FAIL redir_pc_out: got %h expected 20", pc_out); end
        inst_ready = 1'b1;
        enqueue(32'h20, 6);
        for (int cyc = 0; cyc < 40 && exp_q.size() != 0; cyc++) begin
            if (inst_valid && inst_ready) begin
                e = exp_q.pop_front();
                checks++; if (instruccion !== e.data) begin errors++; $display("FAIL redir_word: got %h expected %h", instruccion, e.data); end
                checks++; if (inst_pc !== e.pc) begin errors++; $display("FAIL redir_pc: got %h expected %h", inst_pc, e.pc); end
            end
            tick();
        end
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL redir_timeout: %0d words left expected 0", exp_q.size()); end
    endtask

    task automatic test_wrap();
        do_reset();
        en_fetch = 1'b1; inst_ready = 1'b1;
        redirect = 1'b1; redirect_pc = 32'hFC;
        tick();
        redirect = 1'b0;
        enqueue(32'hFC, 4);
        for (int cyc = 0; cyc < 40 && exp_q.size() != 0; cyc++) begin
            if (inst_valid && inst_ready) begin
                e = exp_q.pop_front();
                checks++; if (instruccion !== e.data) begin errors++; $display("FAIL wrap_word: got %h expected %h", instruccion, e.data); end
                checks++; if (inst_pc !== e.pc) begin errors++; $display("FAIL wrap_pc: got %h expected %h", inst_pc, e.pc); end
            end
            tick();
        end
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL wrap_timeout: %0d words left expected 0", exp_q.size()); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        en_fetch = 1'b1; inst_ready = 1'b0;
        repeat (4) tick();
        checks++; if (fifo_count !== 3'd3) begin errors++; $display("FAIL rmid_pre_count: got %0d expected 3", fifo_count); end
        #2;
        rst_CPU_n = 1'b0;
        #1;
        checks++; if (fifo_count !== 3'd0) begin errors++; $display("FAIL rmid_count: got %0d expected 0", fifo_count); end
        checks++; if (pc_out !== 32'h0) begin errors++; $display("FAIL rmid_pc_out: got %h expected 0", pc_out); end
        checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL rmid_valid: got %b expected 0", inst_valid); end
        tick();
        rst_CPU_n = 1'b1; inst_ready = 1'b1;
        enqueue(32'h0, 5);
        for (int cyc = 0; cyc < 40 && exp_q.size() != 0; cyc++) begin
            if (inst_valid && inst_ready) begin
                e = exp_q.pop_front();
                checks++; if (instruccion !== e.data) begin errors++; $display("FAIL rmid_word: got %h expected %h", instruccion, e.data); end
                checks++; if (inst_pc !== e.pc) begin errors++; $display("FAIL rmid_pc: got %h expected %h", inst_pc, e.pc); end
            end
            tick();
        end
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL rmid_timeout: %0d words left expected 0", exp_q.size()); end
    endtask

    task automatic test_halt();
        do_reset();
        dut.instBank[3] = 32'hFFFF_FFFF;
        model_bank[3]   = 32'hFFFF_FFFF;
        en_fetch = 1'b1; inst_ready = 1'b1;
`ifdef FETCH_HALT_DETECT_EN
        enqueue(32'h0, 4);
`else
        enqueue(32'h0, 6);
`endif
        for (int cyc = 0; cyc < 40 && exp_q.size() != 0; cyc++) begin
            if (inst_valid && inst_ready) begin
                e = exp_q.pop_front();
                checks++; if (instruccion !== e.data) begin errors++; $display("FAIL halt_word: got %h expected %h", instruccion, e.data); end
                checks++; if (inst_pc !== e.pc) begin errors++; $display("FAIL halt_pc: got %h expected %h", inst_pc, e.pc); end
            end
            tick();
        end
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL halt_timeout: %0d words left expected 0", exp_q.size()); end
`ifdef FETCH_HALT_DETECT_EN
        for (int cyc = 0; cyc < 4; cyc++) begin
            checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL halt_extra_word: got valid %b word %h expected no word", inst_valid, instruccion); end
            tick();
        end
        checks++; if (halted !== 1'b1) begin errors++; $display("FAIL halt_flag: got %b expected 1", halted); end
        checks++; if (pc_out !== 32'h10) begin errors++; $display("FAIL halt_pc_out: got %h expected 10", pc_out); end
        redirect = 1'b1; redirect_pc = 32'h0;
        tick();
        redirect = 1'b0;
        checks++; if (halted !== 1'b0) begin errors++; $display("FAIL halt_clear: got %b expected 0", halted); end
        enqueue(32'h0, 2);
        for (int cyc = 0; cyc < 40 && exp_q.size() != 0; cyc++) begin
            if (inst_valid && inst_ready) begin
                e = exp_q.pop_front();
                checks++; if (instruccion !== e.data) begin errors++; $display("FAIL halt_restart_word: got %h expected %h", instruccion, e.data); end
                checks++; if (inst_pc !== e.pc) begin errors++; $display("FAIL halt_restart_pc: got %h expected %h", inst_pc, e.pc); end
            end
            tick();
        end
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL halt_restart_timeout: %0d words left expected 0", exp_q.size()); end
`else
        checks++; if (halted !== 1'b0) begin errors++; $display("FAIL halt_tied: got %b expected 0", halted); end
`endif
        dut.instBank[3] = 32'h4;
        model_bank[3]   = 32'h4;
    endtask

    initial begin
        for (int i = 0; i < 64; i++) begin
            model_bank[i]   = 32'(i + 1);
            dut.instBank[i] = 32'(i + 1);
        end
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect();
        test_wrap();
        test_reset_mid();
        test_halt();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fetch_prefetch_unit.md
Name: fetch_prefetch_unit

Overview:
- Instruction fetch stage directly upstream of the R-type datapath (CPUControlRType).
- Owns the PC and a synchronous instruction memory (instBank), which benches preload with $readmemb.
- Buffers fetched words in a small first-word-fall-through prefetch FIFO.
- Hands instructions downstream over a valid/ready handshake and supports stall and redirect (flush).

Parameters:
- DATA_W, 32: instruction and PC width.
- MEM_DEPTH, 64: instBank depth in words; power of 2.
- FIFO_DEPTH, 4: prefetch FIFO entries; power of 2, ≥2.
- RESET_PC, 32'h0000_0000: PC value loaded on reset.
- HALT_WORD, 32'hFFFF_FFFF: halt encoding; used only with the optional feature.

Ports:
- clk_CPU  in  1  CPU clock, rising edge.
- rst_CPU_n  in  1  asynchronous active-low reset.
- en_fetch  in  1  global fetch enable; 0 = no new memory reads.
- redirect  in  1  flush request, single-cycle pulse.
- redirect_pc  in  32  new PC when redirect=1.
- inst_ready  in  1  downstream accepts the head entry.
- inst_valid  out  1  FIFO non-empty.
- instruccion  out  32  head instruction; 0 when inst_valid=0.
- inst_pc  out  32  PC of the head instruction; 0 when inst_valid=0.
- fifo_count  out  $clog2(FIFO_DEPTH)+1  occupied entries.
- pc_out  out  32  next PC to fetch.
- halted  out  1  halt latched; tied 0 without the feature.

Behaviour:
- Reset: one clock, clk_CPU; reset is asynchronous and active-low (rst_CPU_n). While asserted: pc=RESET_PC, FIFO empty, inflight_q=0, halted=0, all outputs 0 except pc_out=RESET_PC.
- Issue condition (per edge): en_fetch & !redirect & !halted & !halt_pending & (fifo_count + inflight_q < FIFO_DEPTH).
- On issue:
  - rdata_q <= instBank[pc[$clog2(MEM_DEPTH)+1:2]], so the address wraps modulo MEM_DEPTH.
  - pcq <= pc; inflight_q <= 1; pc <= pc+4, wrapping at 2^32.
- No issue: inflight_q <= 0; pc holds.
- Push: at any edge with inflight_q=1 and no redirect, {rdata_q, pcq} is written to the FIFO tail.
- Pop: at any edge with inst_valid & inst_ready & !redirect; the head advances.
- Latency: first issue at edge E0 → push at E1 → inst_valid=1 after E1 (2 edges).
- Throughput: with inst_ready held at 1, one instruction per cycle in steady state.
- Credit rule: the credit check guarantees a push never targets a full FIFO. A pop does not grant credit in the same cycle.
- Simultaneous push+pop: fifo_count unchanged; head/tail pointers wrap modulo FIFO_DEPTH.
- Pop when empty: ignored.
- inst_ready while inst_valid=0: ignored.
- Redirect (highest priority), at the edge:
  - FIFO emptied; inflight word discarded (no push); no pop counted.
  - pc <= {redirect_pc[31:2], 2'b00}; halted <= 0.
  - No issue that edge; fetch resumes at the next edge.
- en_fetch=0: an inflight word still completes its push; the FIFO still drains.
- Reset mid-operation: state clears immediately (asynchronous); FIFO contents lost. The first issue occurs at the first edge after release.
- Outputs are driven from FIFO head registers plus the count; no combinational path from inst_ready to inst_valid.

Optional Feature:
- Macro: FETCH_HALT_DETECT_EN.
- Defined:
  - halt_pending = inflight_q & (rdata_q == HALT_WORD).
  - halt_pending blocks issue in the same cycle.
  - The halt word is still pushed; halted <= 1 at that push edge.
  - pc_out stays at halt_addr+4; no further issues until redirect or reset.
- Undefined: halt_pending=0, halted tied 0; HALT_WORD is fetched like any instruction.

Test Plan:
- Fill/stream: instBank[i]=i+1, en_fetch=1, inst_ready=1 after reset.
  - inst_valid rises 2 edges after the first issue.
  - Consumed words are 1,2,3…, with inst_pc 0,4,8….
- Backpressure: inst_ready=0, stream running.
  - fifo_count saturates at 4; pc_out stops at 16; no overwrite.
  - On inst_ready=1, words 1..4 are delivered in order.
- Redirect mid-stream: FIFO holding 2 entries plus 1 inflight, redirect=1 with redirect_pc=32'h23.
  - At the next edge: fifo_count=0, inst_valid=0, pc_out=32'h20.
  - Subsequent words come from instBank[8]… with inst_pc 32'h20….
- Wrap: MEM_DEPTH=64, redirect_pc=32'hFC.
  - Words instBank[63] then instBank[0]; inst_pc 32'hFC, 32'h100.
- Reset mid-operation: assert rst_CPU_n=0 between clock edges with fifo_count=3.
  - Outputs clear immediately: fifo_count=0, pc_out=0, inst_valid=0.
  - After release, streaming restarts from word 1.
- Halt (FETCH_HALT_DETECT_EN defined): instBank[3]=32'hFFFFFFFF.
  - Words 1,2,3,FFFFFFFF are delivered; halted=1; pc_out=16; no fifth word.
  - A redirect to 0 clears halted and restarts fetch.
  - With the macro undefined: instBank[4] follows.
